ann_layer_sequencer: RTL and testbench
======================================

Name: ann_layer_sequencer

Overview:
- Controller that sequences the shared single-MAC neuron datapath through a two-layer forward pass: the hidden layer first, then the output layer.
- Drives the read addresses for the value, weight and bias memories, plus the accumulator load/enable, result-store strobes and the hidden-layer select.
- Sits between the top-level start/done interface and the datapath; it replaces the bare ld/ready controller.

Parameters:
- IN_CNT, 62, number of network inputs (hidden-layer fan-in).
- HID_CNT, 30, number of hidden neurons (output-layer fan-in).
- OUT_CNT, 10, number of output neurons.
- MAC_LAT, 2, datapath pipeline depth from acc_en to the accumulator holding the final sum; minimum 1.
- Derived, not overridable:
  - VAW = clog2(max(IN_CNT,HID_CNT))
  - WAW = clog2(IN_CNT*HID_CNT + HID_CNT*OUT_CNT)
  - BAW = clog2(HID_CNT+OUT_CNT)
  - SAW = clog2(max(HID_CNT,OUT_CNT))

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, pulse that begins a forward pass; accepted only in IDLE.
- value_addr, out, VAW, input-vector index (layer 0) or hidden-buffer index (layer 1).
- weight_addr, out, WAW, linear weight-memory address.
- bias_addr, out, BAW, global neuron index into bias memory.
- ld, out, 1, load accumulator with bias (clears previous sum).
- acc_en, out, 1, value/weight pair valid this cycle.
- store, out, 1, write the activated result.
- store_addr, out, SAW, neuron index within the current layer.
- hidden, out, 1, 1 while processing layer 0; routes results to the hidden buffer and value reads to the input memory.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse at the end of the pass.

Behaviour:
- Reset: state goes to IDLE. All outputs are 0, including the address counters and hidden. Reset in any state aborts the pass; no store is issued afterwards.
- States: IDLE, LOAD, MAC, DRAIN, STORE, DONE.
- IDLE:
  - start=1 moves to LOAD next cycle, with layer=0, neuron=0, w_ptr=0 and hidden=1.
  - start is ignored in every other state, including DONE.
- LOAD (1 cycle): ld=1, bias_addr = (layer ? HID_CNT : 0) + neuron. Then go to MAC with k=0.
- MAC (K cycles):
  - K = IN_CNT for layer 0, HID_CNT for layer 1.
  - Each cycle: acc_en=1, value_addr=k, weight_addr=w_ptr; then k++ and w_ptr++.
  - At k=K-1, go to DRAIN.
- DRAIN: MAC_LAT cycles with no strobes, then go to STORE.
- STORE (1 cycle): store=1, store_addr=neuron, hidden reflects the current layer. Next state:
  - neuron < N-1 (N = HID_CNT for layer 0, OUT_CNT for layer 1): neuron++, go to LOAD.
  - Otherwise, if layer 0: layer=1, neuron=0, go to LOAD. w_ptr continues, so layer-1 weights start at IN_CNT*HID_CNT.
  - Otherwise: go to DONE.
- DONE (1 cycle): done=1, hidden=0. Return to IDLE.
- Outside their qualifying states, value_addr, weight_addr, bias_addr and store_addr are driven to 0.
- All outputs are registered, i.e. decoded from registered state and counters. They change only on clk.
- Cycles per neuron: 2+K+MAC_LAT.
- Total pass length, start to done inclusive of the DONE cycle: HID_CNT*(2+IN_CNT+MAC_LAT) + OUT_CNT*(2+HID_CNT+MAC_LAT) + 1. The cycle that accepts start is excluded from this count.
- Counter widths are sized exactly from the derived widths. No counter wraps within a legal pass.
- w_ptr reaching its maximum value, IN*HID + HID*OUT - 1, on the last MAC of the last neuron is legal.

Decomposition:
- Package ann_ctrl_pkg holds:
  - the state enum (IDLE..DONE);
  - a clog2 constant function;
  - the derived-width localparams as functions of the parameters.
- Sub-module ann_index_counter: a modulo-N counter with synchronous clear, enable and a last flag.
  - Instantiated for k, neuron and w_ptr.
  - For w_ptr, N is the total weight count.

Test Plan:
- Small config, IN_CNT=3, HID_CNT=2, OUT_CNT=2, MAC_LAT=2; start pulse:
  - done asserts exactly 27 cycles after the first LOAD cycle;
  - busy is high throughout;
  - store is seen 4 times with (hidden, store_addr) = (1,0), (1,1), (0,0), (0,1).
- Same config, address trace:
  - weight_addr during the acc_en cycles is 0..5 for layer 0 and 6..9 for layer 1;
  - value_addr is 0,1,2 per layer-0 neuron and 0,1 per layer-1 neuron;
  - bias_addr at the ld cycles is 0, 1, 2, 3.
- start held high continuously: only one pass runs until done; a new pass begins in LOAD only on the cycle after the return to IDLE.
- rst asserted on the 2nd MAC cycle of neuron 1: next cycle, all outputs are 0 and state is IDLE; no store occurs; a subsequent start runs a full, correct pass.
- MAC_LAT=1 with default sizes:
  - the first store occurs 65 cycles after the first LOAD (LOAD + 62 MAC + 1 DRAIN + STORE);
  - the total pass is 30*65 + 10*33 + 1 = 2281 cycles.

Source files
------------

// File: rtl/ann_ctrl_pkg.sv
// Shared definitions for the two-layer ANN sequencer.
// Holds the controller state encoding, a constant clog2 helper and the
// derived address-width functions.
package ann_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      MAC   = 3'd2,
      DRAIN = 3'd3,
      STORE = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam int unsigned IN_CNT_DEF  = 62;
   localparam int unsigned HID_CNT_DEF = 30;
   localparam int unsigned OUT_CNT_DEF = 10;
   localparam int unsigned MAC_LAT_DEF = 2;

   // Ceiling log2, never below 1 so a single-entry range still gets a bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 1;
      while ((64'd1 << r) < 64'(n)) r++;
      return r;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Value-address width: covers the larger fan-in.
   function automatic int unsigned vaw_f(input int unsigned in_cnt, input int unsigned hid_cnt);
      return clog2(max_u(in_cnt, hid_cnt));
   endfunction

   // Weight-address width: both layers' weights share one linear memory.
   function automatic int unsigned waw_f(input int unsigned in_cnt, input int unsigned hid_cnt,
                                         input int unsigned out_cnt);
      return clog2(in_cnt * hid_cnt + hid_cnt * out_cnt);
   endfunction

   // Bias-address width: one bias per neuron across both layers.
   function automatic int unsigned baw_f(input int unsigned hid_cnt, input int unsigned out_cnt);
      return clog2(hid_cnt + out_cnt);
   endfunction

   // Store-address width: neuron index within a layer.
   function automatic int unsigned saw_f(input int unsigned hid_cnt, input int unsigned out_cnt);
      return clog2(max_u(hid_cnt, out_cnt));
   endfunction

endpackage

// File: rtl/ann_index_counter.sv
// Modulo counter with synchronous clear and enable.
// Ports: clk, rst (sync, active-high), clr (sync clear), en (advance),
//        max_val (terminal count, wraps to 0 after it), count, last (count==max_val).
module ann_index_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] max_val,
   output logic [W-1:0] count,
   output logic         last
);

   assign last = (count == max_val);

   // Count register: clear has priority over advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= last ? '0 : count + W'(1);
      end
   end

endmodule

// File: rtl/ann_layer_sequencer.sv
// Sequences the shared single-MAC neuron datapath through a two-layer
// forward pass (hidden layer, then output layer).
// Ports: clk, rst (sync, active-high), start (accepted in IDLE only);
//        value_addr/weight_addr/bias_addr memory read addresses;
//        ld (bias load), acc_en (MAC pair valid), store/store_addr (result write);
//        hidden (layer-0 select), busy, done (one-cycle end-of-pass pulse).
// All outputs decode registered state and counters only.
module ann_layer_sequencer
   import ann_ctrl_pkg::*;
#(
   parameter  int unsigned IN_CNT  = IN_CNT_DEF,
   parameter  int unsigned HID_CNT = HID_CNT_DEF,
   parameter  int unsigned OUT_CNT = OUT_CNT_DEF,
   parameter  int unsigned MAC_LAT = MAC_LAT_DEF,
   localparam int unsigned VAW     = vaw_f(IN_CNT, HID_CNT),
   localparam int unsigned WAW     = waw_f(IN_CNT, HID_CNT, OUT_CNT),
   localparam int unsigned BAW     = baw_f(HID_CNT, OUT_CNT),
   localparam int unsigned SAW     = saw_f(HID_CNT, OUT_CNT)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   output logic [VAW-1:0] value_addr,
   output logic [WAW-1:0] weight_addr,
   output logic [BAW-1:0] bias_addr,
   output logic           ld,
   output logic           acc_en,
   output logic           store,
   output logic [SAW-1:0] store_addr,
   output logic           hidden,
   output logic           busy,
   output logic           done
);

   localparam int unsigned DW    = clog2(MAC_LAT);
   localparam int unsigned W_TOT = IN_CNT * HID_CNT + HID_CNT * OUT_CNT;

   state_t state_q, state_d;
   logic   layer_q;

   logic [VAW-1:0] k;
   logic           k_last;
   logic [SAW-1:0] neuron;
   logic           n_last;
   logic [WAW-1:0] w_ptr;
   logic           w_last;
   logic [DW-1:0]  drain_cnt;
   logic           drain_last;

   logic [VAW-1:0] k_max;
   logic [SAW-1:0] n_max;

   // Per-layer terminal counts for the fan-in and neuron loops.
   assign k_max = layer_q ? VAW'(HID_CNT - 1) : VAW'(IN_CNT - 1);
   assign n_max = layer_q ? SAW'(OUT_CNT - 1) : SAW'(HID_CNT - 1);

   // Fan-in index within the current neuron.
   ann_index_counter #(.W(VAW)) u_k_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q == LOAD),
      .en      (state_q == MAC),
      .max_val (k_max),
      .count   (k),
      .last    (k_last)
   );

   // Neuron index; wraps to 0 on the layer switch and at end of pass.
   ann_index_counter #(.W(SAW)) u_n_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q == IDLE),
      .en      (state_q == STORE),
      .max_val (n_max),
      .count   (neuron),
      .last    (n_last)
   );

   // Linear weight pointer, runs across both layers without reset.
   ann_index_counter #(.W(WAW)) u_w_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q == IDLE),
      .en      (state_q == MAC),
      .max_val (WAW'(W_TOT - 1)),
      .count   (w_ptr),
      .last    (w_last)
   );

   // Pipeline drain timer; wraps to 0 by itself on the last drain cycle.
   ann_index_counter #(.W(DW)) u_d_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q == IDLE),
      .en      (state_q == DRAIN),
      .max_val (DW'(MAC_LAT - 1)),
      .count   (drain_cnt),
      .last    (drain_last)
   );

   // State and layer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         layer_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE) begin
            layer_q <= 1'b0;
         end else if (state_q == STORE && n_last && !layer_q) begin
            layer_q <= 1'b1;
         end
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d     = state_q;
      value_addr  = '0;
      weight_addr = '0;
      bias_addr   = '0;
      ld          = 1'b0;
      acc_en      = 1'b0;
      store       = 1'b0;
      store_addr  = '0;
      hidden      = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;

      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) state_d = LOAD;
         end
         LOAD: begin
            ld        = 1'b1;
            hidden    = !layer_q;
            bias_addr = BAW'(layer_q ? HID_CNT : 32'd0) + BAW'(neuron);
            state_d   = MAC;
         end
         MAC: begin
            acc_en      = 1'b1;
            hidden      = !layer_q;
            value_addr  = k;
            weight_addr = w_ptr;
            // w_last can only coincide with the final k_last of the pass.
            if (k_last || w_last) state_d = DRAIN;
         end
         DRAIN: begin
            hidden = !layer_q;
            if (drain_last) state_d = STORE;
         end
         STORE: begin
            store      = 1'b1;
            hidden     = !layer_q;
            store_addr = neuron;
            state_d    = (n_last && layer_q) ? DONE : LOAD;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ann_layer_sequencer.sv
// Scoreboard bench for ann_layer_sequencer: a small-configuration DUT is
// checked event-by-event against a hand-computed pass table, and a
// default-size DUT with MAC_LAT=1 is checked for pass timing.
`timescale 1ns/1ps
module tb_ann_layer_sequencer;

   typedef struct {
      int kind;   // 0=ld, 1=acc_en, 2=store, 3=done
      int a;      // bias_addr / value_addr / hidden
      int b;      // - / weight_addr / store_addr
   } ev_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   // Small DUT: IN=3, HID=2, OUT=2, MAC_LAT=2
   logic       rst, start;
   logic [1:0] value_addr;
   logic [3:0] weight_addr;
   logic [1:0] bias_addr;
   logic       ld, acc_en, store, hidden, busy, done;
   logic [0:0] store_addr;

   ann_layer_sequencer #(.IN_CNT(3), .HID_CNT(2), .OUT_CNT(2), .MAC_LAT(2)) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .value_addr(value_addr), .weight_addr(weight_addr), .bias_addr(bias_addr),
      .ld(ld), .acc_en(acc_en), .store(store), .store_addr(store_addr),
      .hidden(hidden), .busy(busy), .done(done)
   );

   // Default-size DUT with MAC_LAT=1
   logic        rst_b, start_b;
   logic [5:0]  b_value_addr;
   logic [11:0] b_weight_addr;
   logic [5:0]  b_bias_addr;
   logic        b_ld, b_acc_en, b_store, b_hidden, b_busy, b_done;
   logic [4:0]  b_store_addr;

   ann_layer_sequencer #(.MAC_LAT(1)) u_big (
      .clk(clk), .rst(rst_b), .start(start_b),
      .value_addr(b_value_addr), .weight_addr(b_weight_addr), .bias_addr(b_bias_addr),
      .ld(b_ld), .acc_en(b_acc_en), .store(b_store), .store_addr(b_store_addr),
      .hidden(b_hidden), .busy(b_busy), .done(b_done)
   );

   // Hand-computed event sequence of one small-configuration pass.
   ev_t pass_tbl [19] = '{
      '{0,0,0}, '{1,0,0}, '{1,1,1}, '{1,2,2}, '{2,1,0},
      '{0,1,0}, '{1,0,3}, '{1,1,4}, '{1,2,5}, '{2,1,1},
      '{0,2,0}, '{1,0,6}, '{1,1,7}, '{2,0,0},
      '{0,3,0}, '{1,0,8}, '{1,1,9}, '{2,0,1},
      '{3,0,0}
   };

   ev_t exp_q [$];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic push_pass();
      for (int i = 0; i < 19; i++) exp_q.push_back(pass_tbl[i]);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk({nm, "_done_seen"}, int'(seen), 1);
   endtask

   // Monitor: pops one expected event per strobed cycle; also tracks busy.
   initial begin : monitor
      ev_t e;
      ev_t a;
      int  first_ld;
      bit  active;
      first_ld = 0;
      active   = 1'b0;
      forever begin
         @(negedge clk);
         if (ld && !active) begin
            active   = 1'b1;
            first_ld = cyc;
         end
         chk("busy", int'(busy), int'(active));
         if (ld || acc_en || store || done) begin
            a.kind = ld ? 0 : acc_en ? 1 : store ? 2 : 3;
            a.a    = ld ? int'(bias_addr) : acc_en ? int'(value_addr) : store ? int'(hidden) : 0;
            a.b    = acc_en ? int'(weight_addr) : store ? int'(store_addr) : 0;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d expected none (t=%0t)",
                        a.kind, a.a, a.b, $time);
            end else begin
               e = exp_q.pop_front();
               chk("ev_kind", a.kind, e.kind);
               chk("ev_a", a.a, e.a);
               chk("ev_b", a.b, e.b);
            end
            if (done) begin
               chk("pass_len", cyc - first_ld + 1, 27);
               active = 1'b0;
            end
         end
         if (rst) active = 1'b0;
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin : stim
      int c0, st_c, dn_c, nld, nst;
      rst = 1'b1; start = 1'b0;
      rst_b = 1'b1; start_b = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0; rst_b = 1'b0;
      @(negedge clk);
      chk("reset_outs_small", int'(|{value_addr, weight_addr, bias_addr, ld, acc_en, store,
                                     store_addr, hidden, busy, done}), 0);
      chk("reset_outs_big", int'(|{b_value_addr, b_weight_addr, b_bias_addr, b_ld, b_acc_en,
                                   b_store, b_store_addr, b_hidden, b_busy, b_done}), 0);

      // Single pass from a start pulse
      push_pass();
      pulse_start();
      wait_done("pass1");

      // start held high: one pass, IDLE for a cycle, then the next LOAD
      push_pass();
      push_pass();
      @(posedge clk); #1 start = 1'b1;
      wait_done("held1");
      @(negedge clk);
      chk("held_idle_busy", int'(busy), 0);
      chk("held_idle_ld", int'(ld), 0);
      @(negedge clk);
      chk("held_restart_ld", int'(ld), 1);
      @(posedge clk); #1 start = 1'b0;
      wait_done("held2");

      // Reset on the 2nd MAC cycle of neuron 1 aborts the pass
      for (int i = 0; i < 8; i++) exp_q.push_back(pass_tbl[i]);
      pulse_start();
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_outs_zero", int'(|{value_addr, weight_addr, bias_addr, ld, acc_en, store,
                                    store_addr, hidden, busy, done}), 0);
      repeat (10) @(negedge clk);
      chk("abort_queue_empty", exp_q.size(), 0);

      // Full pass after the abort
      push_pass();
      pulse_start();
      wait_done("after_abort");

      // Default sizes with MAC_LAT=1: store and done timing
      @(posedge clk); #1 start_b = 1'b1;
      @(posedge clk); #1 start_b = 1'b0;
      c0   = cyc;
      st_c = -1;
      dn_c = -1;
      nld  = 0;
      nst  = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (b_ld) nld++;
         if (b_store) begin
            nst++;
            if (st_c < 0) st_c = cyc;
         end
         if (b_done) begin
            dn_c = cyc;
            break;
         end
      end
      chk("big_done_seen", int'(dn_c >= 0), 1);
      chk("big_first_store_len", st_c - c0 + 1, 65);
      chk("big_pass_len", dn_c - c0 + 1, 2281);
      chk("big_ld_count", nld, 40);
      chk("big_store_count", nst, 40);
      @(negedge clk);
      chk("big_idle_busy", int'(b_busy), 0);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
